dense_layer_result_collector: RTL and testbench
===============================================

Name: dense_layer_result_collector

Overview:
- Downstream consumer of the dense-layer delay register.
- Delay outputs (act_type, cost_type, predict_value, dense_type, backprop_controll) arrive with a start pulse. The dense array's per-neuron results then arrive serially, one element per elem_valid.
- The block latches the control fields and assembles the size results into one packed vector. It presents vector plus fields to the activation/cost stage over a valid/ready handshake, and flags protocol errors.

Parameters:
- size, 3, neurons per dense layer (elements per result vector), >=2
- data_size, 16, bits per result element
- act_type_size, 4, width of act_type
- cost_type_size, 8, width of cost_type
- dense_type_size, 4, width of dense_type
- backprop_controll_size, 100 (32*3+4), width of backprop_controll
- idx_width, $clog2(size), element counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; control inputs valid this cycle
- act_type  in  act_type_size  delayed activation select
- cost_type  in  cost_type_size  delayed cost select
- predict_value  in  data_size*size  delayed target vector
- dense_type  in  dense_type_size  delayed layer type
- backprop_controll  in  backprop_controll_size  delayed backprop control word
- elem_valid  in  1  elem_data valid this cycle
- elem_data  in  data_size  next result element, index order 0..size-1
- out_valid  out  1  assembled result available
- out_ready  in  1  downstream accepts
- y_out  out  data_size*size  packed results, element i at bits [i*data_size +: data_size]
- act_type_out, cost_type_out, predict_value_out, dense_type_out, backprop_controll_out  out  same widths as inputs  latched control fields
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n low, async): state=IDLE, cnt=0, out_valid=0, err=0, y_out=0, all *_out=0. Reset mid-COLLECT or mid-HOLD discards the partial or held result; no output handshake completes.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - start: latch all control inputs into *_out, cnt=0, go to COLLECT.
  - elem_valid in IDLE: element is dropped and err is set.
- COLLECT:
  - elem_valid: write elem_data into slot cnt, cnt+1.
  - When the write is at cnt==size-1: cnt=0, go to HOLD, out_valid=1 from the next cycle.
  - Latency: last element at cycle N gives out_valid high at cycle N+1.
  - Gaps between elem_valid are allowed; there is no timeout.
  - start in COLLECT: ignored, err set, latched fields unchanged.
- HOLD:
  - out_valid=1. y_out and *_out stay stable until out_ready.
  - out_valid && out_ready: transfer completes, out_valid=0 next cycle.
  - Handshake with start in the same cycle: latch new fields, go to COLLECT (back-to-back, no bubble).
  - Handshake without start: go to IDLE.
  - start without out_ready in HOLD: ignored, err set.
  - elem_valid in HOLD: element dropped, err set.
- y_out and *_out are registered. y_out slots not yet written in COLLECT keep the previous result; they are not visible because out_valid=0.
- err is cleared only by reset.
- No arithmetic. Elements are stored bit-exact.

Decomposition:
- Shared package dense_layer_pkg:
  - collector_state_t enum {IDLE, COLLECT, HOLD}
  - width constants ACT_TYPE_SIZE, COST_TYPE_SIZE, DENSE_TYPE_SIZE and BACKPROP_CONTROLL_SIZE (=32*3+4), shared with the delay register.
- One sub-module, dense_layer_ctrl_latch: a load-enabled register bank for the five control fields, reset to 0.
- FSM, counter and vector assembly stay in the top.

Test Plan:
- Basic: size=3. start with act_type=4'h2, cost_type=8'h11, dense_type=4'h1. Then elem 16'h0001, 16'h0002, 16'h0003 on consecutive cycles, out_ready=1 -> out_valid one cycle after the third element, y_out=48'h0003_0002_0001, fields echoed, busy falls the cycle after the handshake.
- Backpressure: as basic with out_ready=0 for 5 cycles -> out_valid held and y_out/fields stable for all 5 cycles; single transfer when out_ready rises.
- Back-to-back: in HOLD, out_ready=1 and start with act_type=4'h5 in the same cycle -> state COLLECT next cycle, act_type_out=4'h5, first vector transferred exactly once.
- Gapped input: elements 16'hAAAA, idle 3 cycles, 16'hBBBB, idle 1 cycle, 16'hCCCC -> y_out=48'hCCCC_BBBB_AAAA, err=0.
- Protocol errors: elem_valid in IDLE, then start during COLLECT -> err=1 and stays 1. The dropped element does not appear in y_out; latched fields come from the first start.
- Reset mid-op: rst_n low after 2 of 3 elements -> all outputs 0 immediately (asynchronous). After release, a full 3-element transaction yields the correct vector.

Source files
------------

// File: rtl/dense_layer_pkg.sv
// Types and width constants shared by the dense-layer delay register and its result collector.
package dense_layer_pkg;

    localparam int ACT_TYPE_SIZE          = 4;
    localparam int COST_TYPE_SIZE         = 8;
    localparam int DENSE_TYPE_SIZE        = 4;
    localparam int BACKPROP_CONTROLL_SIZE = 32 * 3 + 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } collector_state_t;

endpackage

// File: rtl/dense_layer_result_collector_if.sv
// Result bus from the collector to the activation/cost stage.
// Handshake: a transfer happens on a rising clk edge where out_valid && out_ready; while
// out_valid is high and out_ready is low, y_out and every *_out field are held stable.
interface dense_layer_result_collector_if
    import dense_layer_pkg::*;
#(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int act_type_size          = ACT_TYPE_SIZE,
    parameter int cost_type_size         = COST_TYPE_SIZE,
    parameter int dense_type_size        = DENSE_TYPE_SIZE,
    parameter int backprop_controll_size = BACKPROP_CONTROLL_SIZE
);

    logic                              out_valid;
    logic                              out_ready;
    logic [data_size*size-1:0]         y_out;
    logic [act_type_size-1:0]          act_type_out;
    logic [cost_type_size-1:0]         cost_type_out;
    logic [data_size*size-1:0]         predict_value_out;
    logic [dense_type_size-1:0]        dense_type_out;
    logic [backprop_controll_size-1:0] backprop_controll_out;

    modport master (
        output out_valid, y_out, act_type_out, cost_type_out,
               predict_value_out, dense_type_out, backprop_controll_out,
        input  out_ready
    );

    modport slave (
        input  out_valid, y_out, act_type_out, cost_type_out,
               predict_value_out, dense_type_out, backprop_controll_out,
        output out_ready
    );

endinterface

// File: rtl/dense_layer_ctrl_latch.sv
// Load-enabled register bank holding the five delayed control fields for one result vector.
module dense_layer_ctrl_latch
    import dense_layer_pkg::*;
#(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int act_type_size          = ACT_TYPE_SIZE,
    parameter int cost_type_size         = COST_TYPE_SIZE,
    parameter int dense_type_size        = DENSE_TYPE_SIZE,
    parameter int backprop_controll_size = BACKPROP_CONTROLL_SIZE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load,
    input  logic [act_type_size-1:0]          act_type_d,
    input  logic [cost_type_size-1:0]         cost_type_d,
    input  logic [data_size*size-1:0]         predict_value_d,
    input  logic [dense_type_size-1:0]        dense_type_d,
    input  logic [backprop_controll_size-1:0] backprop_controll_d,
    output logic [act_type_size-1:0]          act_type_q,
    output logic [cost_type_size-1:0]         cost_type_q,
    output logic [data_size*size-1:0]         predict_value_q,
    output logic [dense_type_size-1:0]        dense_type_q,
    output logic [backprop_controll_size-1:0] backprop_controll_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_type_q          <= '0;
            cost_type_q         <= '0;
            predict_value_q     <= '0;
            dense_type_q        <= '0;
            backprop_controll_q <= '0;
        end else if (load) begin
            act_type_q          <= act_type_d;
            cost_type_q         <= cost_type_d;
            predict_value_q     <= predict_value_d;
            dense_type_q        <= dense_type_d;
            backprop_controll_q <= backprop_controll_d;
        end
    end

endmodule

// File: rtl/dense_layer_result_collector.sv
// Collects the serial per-neuron results of a dense layer into one packed vector and hands
// it, with the control fields latched at start, to the activation/cost stage.
module dense_layer_result_collector
    import dense_layer_pkg::*;
#(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int act_type_size          = ACT_TYPE_SIZE,
    parameter int cost_type_size         = COST_TYPE_SIZE,
    parameter int dense_type_size        = DENSE_TYPE_SIZE,
    parameter int backprop_controll_size = BACKPROP_CONTROLL_SIZE,
    parameter int idx_width              = $clog2(size)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [act_type_size-1:0]          act_type,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [data_size*size-1:0]         predict_value,
    input  logic [dense_type_size-1:0]        dense_type,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    input  logic                              elem_valid,
    input  logic [data_size-1:0]              elem_data,
    output logic                              busy,
    output logic                              err,
    output collector_state_t                  state_dbg,
    dense_layer_result_collector_if.master    res
);

    localparam logic [idx_width-1:0] LAST_IDX = idx_width'(size - 1);

    collector_state_t          state_q, state_d;
    logic [idx_width-1:0]      cnt_q, cnt_d;
    logic [data_size*size-1:0] y_q;
    logic                      err_q;
    logic                      load;
    logic                      wr_en;
    logic                      err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // A start in HOLD is only legal when it coincides with the outgoing handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        wr_en   = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (elem_valid) begin
                    err_set = 1'b1;
                end
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (start) begin
                    err_set = 1'b1;
                end
                if (elem_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + idx_width'(1);
                    end
                end
            end
            HOLD: begin
                if (elem_valid) begin
                    err_set = 1'b1;
                end
                if (res.out_ready) begin
                    if (start) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Unwritten slots keep the previous vector; out_valid is low until all are refreshed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < size; i++) begin
                if (cnt_q == idx_width'(i)) begin
                    y_q[i*data_size +: data_size] <= elem_data;
                end
            end
        end
    end

    dense_layer_ctrl_latch #(
        .size                   (size),
        .data_size              (data_size),
        .act_type_size          (act_type_size),
        .cost_type_size         (cost_type_size),
        .dense_type_size        (dense_type_size),
        .backprop_controll_size (backprop_controll_size)
    ) u_ctrl_latch (
        .clk                 (clk),
        .rst_n               (rst_n),
        .load                (load),
        .act_type_d          (act_type),
        .cost_type_d         (cost_type),
        .predict_value_d     (predict_value),
        .dense_type_d        (dense_type),
        .backprop_controll_d (backprop_controll),
        .act_type_q          (res.act_type_out),
        .cost_type_q         (res.cost_type_out),
        .predict_value_q     (res.predict_value_out),
        .dense_type_q        (res.dense_type_out),
        .backprop_controll_q (res.backprop_controll_out)
    );

    assign res.out_valid = (state_q == HOLD);
    assign res.y_out     = y_q;
    assign busy          = (state_q != IDLE);
    assign err           = err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_dense_layer_result_collector.sv
// Directed bench for the dense-layer result collector: handshake, latency, backpressure,
// back-to-back transfer, protocol errors and asynchronous reset.
module tb_dense_layer_result_collector;
    import dense_layer_pkg::*;

    localparam int SIZE = 3;
    localparam int DW   = 16;
    localparam int VW   = SIZE * DW;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              start;
    logic [ACT_TYPE_SIZE-1:0]          act_type;
    logic [COST_TYPE_SIZE-1:0]         cost_type;
    logic [VW-1:0]                     predict_value;
    logic [DENSE_TYPE_SIZE-1:0]        dense_type;
    logic [BACKPROP_CONTROLL_SIZE-1:0] backprop_controll;
    logic                              elem_valid;
    logic [DW-1:0]                     elem_data;
    logic                              busy;
    logic                              err;
    collector_state_t                  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [VW-1:0] acc_q[$];

    dense_layer_result_collector_if #(.size(SIZE), .data_size(DW)) res ();

    dense_layer_result_collector #(.size(SIZE), .data_size(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .act_type          (act_type),
        .cost_type         (cost_type),
        .predict_value     (predict_value),
        .dense_type        (dense_type),
        .backprop_controll (backprop_controll),
        .elem_valid        (elem_valid),
        .elem_data         (elem_data),
        .busy              (busy),
        .err               (err),
        .state_dbg         (state_dbg),
        .res               (res)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Records every completed output transfer
    always @(posedge clk) begin
        if (rst_n && res.out_valid && res.out_ready) begin
            acc_q.push_back(res.y_out);
        end
    end

    // Driver tasks: called at a falling edge, return at a falling edge
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_start(input logic [3:0] a, input logic [7:0] c, input logic [3:0] d,
                               input logic [VW-1:0] p, input logic [99:0] b);
        start = 1'b1; act_type = a; cost_type = c; dense_type = d;
        predict_value = p; backprop_controll = b;
        @(negedge clk);
        start = 1'b0; act_type = ~a; cost_type = ~c; dense_type = ~d;
        predict_value = ~p; backprop_controll = ~b;
    endtask

    task automatic send_elem(input logic [DW-1:0] v);
        elem_valid = 1'b1; elem_data = v;
        @(negedge clk);
        elem_valid = 1'b0; elem_data = ~v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++; if (res.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", res.out_valid); end
        checks++; if (res.y_out !== '0) begin errors++; $display("FAIL reset_y_out: got %h want 0", res.y_out); end
        checks++; if (res.act_type_out !== '0 || res.cost_type_out !== '0 || res.dense_type_out !== '0)
            begin errors++; $display("FAIL reset_fields: act %h cost %h dense %h want 0", res.act_type_out, res.cost_type_out, res.dense_type_out); end
        checks++; if (res.predict_value_out !== '0 || res.backprop_controll_out !== '0)
            begin errors++; $display("FAIL reset_wide_fields: predict %h backprop %h want 0", res.predict_value_out, res.backprop_controll_out); end
        checks++; if (err !== 1'b0 || busy !== 1'b0 || state_dbg !== IDLE)
            begin errors++; $display("FAIL reset_status: err %b busy %b state %0d want 0 0 0", err, busy, state_dbg); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        acc_q.delete();
        res.out_ready = 1'b1;
        drive_start(4'h2, 8'h11, 4'h1, 48'h1234_5678_9ABC, 100'h5_0000_0001_0000_0002_0000_0003);
        checks++; if (state_dbg !== COLLECT || busy !== 1'b1) begin errors++; $display("FAIL basic_collect: state %0d busy %b want 1 1", state_dbg, busy); end
        send_elem(16'h0001);
        send_elem(16'h0002);
        checks++; if (res.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", res.out_valid); end
        send_elem(16'h0003);
        checks++; if (res.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b want 1", res.out_valid); end
        checks++; if (res.y_out !== 48'h0003_0002_0001) begin errors++; $display("FAIL basic_y_out: got %h want 000300020001", res.y_out); end
        checks++; if (res.act_type_out !== 4'h2 || res.cost_type_out !== 8'h11 || res.dense_type_out !== 4'h1)
            begin errors++; $display("FAIL basic_fields: act %h cost %h dense %h want 2 11 1", res.act_type_out, res.cost_type_out, res.dense_type_out); end
        checks++; if (res.predict_value_out !== 48'h1234_5678_9ABC || res.backprop_controll_out !== 100'h5_0000_0001_0000_0002_0000_0003)
            begin errors++; $display("FAIL basic_wide_fields: predict %h backprop %h", res.predict_value_out, res.backprop_controll_out); end
        step();
        checks++; if (res.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after_xfer: out_valid %b busy %b want 0 0", res.out_valid, busy); end
        checks++; if (acc_q.size() != 1 || acc_q[0] !== 48'h0003_0002_0001)
            begin errors++; $display("FAIL basic_transfer: count %0d want 1 of 000300020001", acc_q.size()); end
    endtask

    task automatic test_backpressure();
        acc_q.delete();
        res.out_ready = 1'b0;
        drive_start(4'h3, 8'h22, 4'h2, 48'hAAAA_5555_0F0F, 100'h1);
        send_elem(16'h0010);
        send_elem(16'h0020);
        send_elem(16'h0030);
        for (int i = 0; i < 5; i++) begin
            checks++; if (res.out_valid !== 1'b1 || res.y_out !== 48'h0030_0020_0010)
                begin errors++; $display("FAIL bp_hold[%0d]: valid %b y %h want 1 003000200010", i, res.out_valid, res.y_out); end
            checks++; if (res.act_type_out !== 4'h3 || res.predict_value_out !== 48'hAAAA_5555_0F0F || acc_q.size() != 0)
                begin errors++; $display("FAIL bp_fields[%0d]: act %h predict %h xfers %0d", i, res.act_type_out, res.predict_value_out, acc_q.size()); end
            step();
        end
        res.out_ready = 1'b1;
        step();
        checks++; if (acc_q.size() != 1 || acc_q[0] !== 48'h0030_0020_0010 || res.out_valid !== 1'b0)
            begin errors++; $display("FAIL bp_release: xfers %0d valid %b want 1 0", acc_q.size(), res.out_valid); end
    endtask

    task automatic test_back_to_back();
        acc_q.delete();
        res.out_ready = 1'b0;
        drive_start(4'h4, 8'h44, 4'h4, 48'h0, 100'h4);
        send_elem(16'h0101);
        send_elem(16'h0202);
        send_elem(16'h0303);
        res.out_ready = 1'b1;
        drive_start(4'h5, 8'h55, 4'h5, 48'h5, 100'h5);
        checks++; if (state_dbg !== COLLECT || res.out_valid !== 1'b0)
            begin errors++; $display("FAIL b2b_state: state %0d valid %b want 1 0", state_dbg, res.out_valid); end
        checks++; if (res.act_type_out !== 4'h5 || res.cost_type_out !== 8'h55)
            begin errors++; $display("FAIL b2b_fields: act %h cost %h want 5 55", res.act_type_out, res.cost_type_out); end
        checks++; if (acc_q.size() != 1 || acc_q[0] !== 48'h0303_0202_0101)
            begin errors++; $display("FAIL b2b_first: xfers %0d want 1 of 030302020101", acc_q.size()); end
        send_elem(16'h0A0A);
        send_elem(16'h0B0B);
        send_elem(16'h0C0C);
        checks++; if (res.y_out !== 48'h0C0C_0B0B_0A0A) begin errors++; $display("FAIL b2b_y_out: got %h want 0C0C0B0B0A0A", res.y_out); end
        step();
        checks++; if (acc_q.size() != 2 || acc_q[1] !== 48'h0C0C_0B0B_0A0A || state_dbg !== IDLE)
            begin errors++; $display("FAIL b2b_second: xfers %0d state %0d want 2 0", acc_q.size(), state_dbg); end
    endtask

    task automatic test_gapped();
        acc_q.delete();
        res.out_ready = 1'b1;
        drive_start(4'h6, 8'h66, 4'h6, 48'h6, 100'h6);
        send_elem(16'hAAAA);
        step(); step(); step();
        send_elem(16'hBBBB);
        step();
        checks++; if (res.out_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid: got %b want 0", res.out_valid); end
        send_elem(16'hCCCC);
        checks++; if (res.out_valid !== 1'b1 || res.y_out !== 48'hCCCC_BBBB_AAAA || err !== 1'b0)
            begin errors++; $display("FAIL gap_result: valid %b y %h err %b want 1 CCCCBBBBAAAA 0", res.out_valid, res.y_out, err); end
        step();
        checks++; if (acc_q.size() != 1 || acc_q[0] !== 48'hCCCC_BBBB_AAAA)
            begin errors++; $display("FAIL gap_transfer: xfers %0d want 1", acc_q.size()); end
    endtask

    task automatic test_protocol_err();
        acc_q.delete();
        res.out_ready = 1'b1;
        send_elem(16'hDEAD);
        checks++; if (err !== 1'b1 || state_dbg !== IDLE) begin errors++; $display("FAIL perr_idle_elem: err %b state %0d want 1 0", err, state_dbg); end
        drive_start(4'h7, 8'h33, 4'h3, 48'h7, 100'h7);
        send_elem(16'h1111);
        drive_start(4'h9, 8'h99, 4'h9, 48'h9, 100'h9);
        checks++; if (err !== 1'b1 || res.act_type_out !== 4'h7 || state_dbg !== COLLECT)
            begin errors++; $display("FAIL perr_start: err %b act %h state %0d want 1 7 1", err, res.act_type_out, state_dbg); end
        send_elem(16'h2222);
        send_elem(16'h3333);
        checks++; if (res.y_out !== 48'h3333_2222_1111 || res.cost_type_out !== 8'h33)
            begin errors++; $display("FAIL perr_result: y %h cost %h want 333322221111 33", res.y_out, res.cost_type_out); end
        step();
        checks++; if (err !== 1'b1 || acc_q.size() != 1) begin errors++; $display("FAIL perr_sticky: err %b xfers %0d want 1 1", err, acc_q.size()); end
    endtask

    task automatic test_reset_mid();
        acc_q.delete();
        res.out_ready = 1'b0;
        drive_start(4'hE, 8'hEE, 4'hE, 48'hE, 100'hE);
        send_elem(16'h4444);
        send_elem(16'h5555);
        rst_n = 1'b0;
        #1;
        checks++; if (res.y_out !== '0 || res.act_type_out !== '0 || res.backprop_controll_out !== '0)
            begin errors++; $display("FAIL rmid_outputs: y %h act %h want 0", res.y_out, res.act_type_out); end
        checks++; if (err !== 1'b0 || busy !== 1'b0 || res.out_valid !== 1'b0 || state_dbg !== IDLE)
            begin errors++; $display("FAIL rmid_status: err %b busy %b valid %b state %0d want 0", err, busy, res.out_valid, state_dbg); end
        step();
        rst_n = 1'b1;
        res.out_ready = 1'b1;
        step();
        drive_start(4'h8, 8'h88, 4'h8, 48'h8, 100'h8);
        send_elem(16'h7777);
        send_elem(16'h8888);
        send_elem(16'h9999);
        checks++; if (res.y_out !== 48'h9999_8888_7777 || res.act_type_out !== 4'h8 || res.out_valid !== 1'b1)
            begin errors++; $display("FAIL rmid_result: y %h act %h valid %b", res.y_out, res.act_type_out, res.out_valid); end
        step();
        checks++; if (acc_q.size() != 1 || acc_q[0] !== 48'h9999_8888_7777)
            begin errors++; $display("FAIL rmid_transfer: xfers %0d want 1", acc_q.size()); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; elem_valid = 1'b0; elem_data = '0;
        act_type = '0; cost_type = '0; predict_value = '0; dense_type = '0;
        backprop_controll = '0; res.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_gapped();
        test_protocol_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
